instr_fetch_queue: RTL and testbench

Instruction fetch front end for the MIPS32 floating-point DSP processor. Sits between `program_counter` / `instruction_mem` and the decode/control stage. It generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel. In-order responses are buffered in a small FIFO, and each instruction is presented to decode with its PC under a valid/ready handshake. A flush input redirects fetch and discards stale in-flight responses.

---
 rtl/instr_fetch_queue.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Purpose  : Sequential fetch-address generator, credit-limited imem request
//            issue, in-order response FIFO and flush-driven stale-drop logic.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [31:0]                imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [31:0]                imem_rsp_data,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr_out,
    output logic [31:0]                instr_pc,
    output logic [31:0]                fetch_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int              CW        = $clog2(DEPTH + 1);
    localparam int              PW        = $clog2(DEPTH);
    localparam logic [CW:0]     c_DEPTH   = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   c_CNT_ONE = CW'(1);
    localparam logic [PW-1:0]   c_PTR_ONE = PW'(1);
    localparam logic [31:0]     c_STEP    = 32'(PC_STEP);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] tag_rd_q, tag_rd_d;
    logic [PW-1:0] tag_wr_q, tag_wr_d;

    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   tag_mem_q  [DEPTH];

    logic w_credit;
    logic w_accept;
    logic w_rsp;
    logic w_keep;
    logic w_pop;
    logic w_not_empty;

    always_comb begin
        w_credit       = (({1'b0, occ_q} + {1'b0, inflight_q}) < c_DEPTH);
        imem_req_valid = reset && !flush && w_credit;
        w_accept       = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error: ignore it.
        w_rsp          = imem_rsp_valid && (inflight_q != '0);
        w_keep         = w_rsp && !flush && (drop_cnt_q == '0);
        w_not_empty    = (occ_q != '0);
        instr_valid    = reset && !flush && w_not_empty;
        w_pop          = instr_valid && instr_ready;
        imem_req_addr  = fetch_pc_q;
        fetch_pc       = fetch_pc_q;
        occupancy      = occ_q;
        instr_out      = w_not_empty ? data_mem_q[rd_ptr_q] : 32'h0;
        instr_pc       = w_not_empty ? pc_mem_q[rd_ptr_q]   : 32'h0;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        occ_d      = occ_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tag_rd_d   = w_rsp    ? tag_rd_q + c_PTR_ONE : tag_rd_q;
        tag_wr_d   = w_accept ? tag_wr_q + c_PTR_ONE : tag_wr_q;

        case ({w_accept, w_rsp})
            2'b10:   inflight_d = inflight_q + c_CNT_ONE;
            2'b01:   inflight_d = inflight_q - c_CNT_ONE;
            default: inflight_d = inflight_q;
        endcase

        if (flush) begin
            // Everything still outstanding is stale; the tag FIFO keeps its
            // entries so those responses retire through it normally.
            fetch_pc_d = flush_pc;
            occ_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            drop_cnt_d = w_rsp ? inflight_q - c_CNT_ONE : inflight_q;
        end else begin
            if (w_accept) begin
                fetch_pc_d = fetch_pc_q + c_STEP;
            end
            if (w_rsp && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - c_CNT_ONE;
            end
            if (w_keep) begin
                wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            end
            case ({w_keep, w_pop})
                2'b10:   occ_d = occ_q + c_CNT_ONE;
                2'b01:   occ_d = occ_q - c_CNT_ONE;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            occ_q      <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    // Storage arrays need no reset: every read is qualified by occupancy.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            tag_mem_q[tag_wr_q] <= fetch_pc_q;
        end
        if (w_keep) begin
            data_mem_q[wr_ptr_q] <= imem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= tag_mem_q[tag_rd_q];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Purpose  : Scoreboard bench for instr_fetch_queue with an in-order imem model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;
    localparam int          c_DEPTH    = 4;
    localparam logic [31:0] c_RESET_PC = 32'hFFFF_FFF8;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] fetch_pc;
    logic [2:0]  occupancy;

    instr_fetch_queue #(
        .DEPTH    (c_DEPTH),
        .RESET_PC (c_RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .fetch_pc       (fetch_pc),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    req_t        memq[$];
    exp_t        sb[$];
    logic [31:0] m_pc;
    int          epoch;
    int          cyc;
    int          lat;
    logic        last_acc;
    int          n_total;
    int          n_bad;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rsp_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    function automatic int stale_count();
        int n = 0;
        foreach (memq[i]) if (memq[i].epoch != epoch) n++;
        return n;
    endfunction

    // Drive one cycle; entered and left 1 time unit after a rising edge.
    task automatic step(input logic f, input logic [31:0] fpc, input logic rdy, input logic ird);
        req_t r;
        exp_t e;
        logic rv;
        logic acc;
        logic pop;
        rv = (memq.size() != 0) && (memq[0].due <= cyc);
        flush          = f;
        flush_pc       = fpc;
        imem_req_ready = rdy;
        instr_ready    = ird;
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? rsp_word(memq[0].addr) : 32'h0;
        #1;
        check("req_valid", 32'(imem_req_valid),
              32'(!f && ((sb.size() + memq.size()) < c_DEPTH)));
        check("fetch_pc", fetch_pc, m_pc);
        if (imem_req_valid) check("req_addr", imem_req_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(!f && (sb.size() != 0)));
        check("occupancy", 32'(occupancy), 32'(sb.size()));
        acc = imem_req_valid && rdy;
        pop = instr_valid && ird;
        if (pop && (sb.size() != 0)) begin
            e = sb.pop_front();
            check("instr_out", instr_out, e.data);
            check("instr_pc", instr_pc, e.pc);
        end
        if (acc) begin
            memq.push_back('{addr: m_pc, epoch: epoch, due: cyc + lat});
            m_pc = m_pc + 32'd4;
        end
        if (rv) begin
            r = memq.pop_front();
            if (!f && (r.epoch == epoch)) sb.push_back('{data: rsp_word(r.addr), pc: r.addr});
        end
        if (f) begin
            sb.delete();
            m_pc = fpc;
            epoch++;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        cyc++;
        check("drop_cnt", 32'(dut.drop_cnt_q), 32'(stale_count()));
        check("inflight", 32'(dut.inflight_q), 32'(memq.size()));
    endtask

    task automatic do_reset(input int new_lat);
        reset          = 1'b0;
        flush          = 1'b0;
        flush_pc       = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        memq.delete();
        sb.delete();
        m_pc = c_RESET_PC;
        lat  = new_lat;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_fetch_pc", fetch_pc, c_RESET_PC);
        reset = 1'b1;
    endtask

    initial begin
        int  acc_cnt;
        bit  found;
        logic [31:0] fpc;
        n_total  = 0;
        n_bad    = 0;
        cyc      = 0;
        epoch    = 0;
        last_acc = 1'b0;

        // Stream at latency 1; addresses wrap past 0xFFFF_FFFC, FIFO pointers wrap.
        do_reset(1);
        for (int i = 0; i < 30; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Decode backpressure: exactly DEPTH requests, then one per pop.
        do_reset(1);
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            if (last_acc) acc_cnt++;
        end
        check("t2_accepts", 32'(acc_cnt), 32'd4);
        check("t2_occ", 32'(occupancy), 32'd4);
        acc_cnt = 0;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            if (last_acc) acc_cnt++;
        end
        check("t2_refill", 32'(acc_cnt), 32'd1);

        // Flush with responses still outstanding at latency 3.
        do_reset(3);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b1, 1'b0);
        check("t3_occ_after_flush", 32'(occupancy), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Flush in the same cycle as a response and a decode pop.
        do_reset(2);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if ((memq.size() != 0) && (memq[0].due <= cyc) && (sb.size() != 0)) found = 1'b1;
            else step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("t4_setup", 32'(found), 32'd1);
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Random ready/flush traffic, including flush targets near the wrap point.
        do_reset(2);
        for (int i = 0; i < 300; i++) begin
            fpc = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 : 32'h0000_1000;
            fpc = fpc + 32'(4 * $urandom_range(0, 7));
            step(($urandom_range(0, 15) == 0), fpc,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset between edges with three entries queued.
        do_reset(1);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (sb.size() == 3) found = 1'b1;
            else step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("t6_setup", 32'(found), 32'd1);
        check("t6_occ_before", 32'(occupancy), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("t6_req_valid", 32'(imem_req_valid), 32'd0);
        check("t6_instr_valid", 32'(instr_valid), 32'd0);
        check("t6_occ", 32'(occupancy), 32'd0);
        check("t6_fetch_pc", fetch_pc, c_RESET_PC);
        check("t6_instr_out", instr_out, 32'h0);
        check("t6_instr_pc", instr_pc, 32'h0);
        do_reset(1);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
